// File: rtl/addb_rr_sched.sv
// addb_rr_sched: round-robin scheduler sharing one SR = DQ + SE reconstruction
// adder among NREQ requesters. Two-stage stallable pipeline (operand register,
// output register) with req/ack on the input side and valid/ready on the output.
// Optional build macro: ADDB_SR_SAT_EN -- saturate SR on signed overflow
// instead of wrapping mod 2^16.
module addb_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   dq,
  input  logic [15*NREQ-1:0]   se,
  output logic [NREQ-1:0]      ack,
  output logic                 sr_valid,
  input  logic                 sr_ready,
  output logic [15:0]          sr,
  output logic [IDW-1:0]       sr_id,
  output logic [15:0]          sr_count
);

  logic [IDW-1:0] ptr;
  logic           v1;
  logic [15:0]    op_dq;
  logic [14:0]    op_se;
  logic [IDW-1:0] op_id;

  logic           s2_adv;
  logic           accept;
  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand;
  logic           take;
  logic [15:0]    sel_dq;
  logic [14:0]    sel_se;

  logic [15:0]    dqi;
  logic [15:0]    sei;
  logic [15:0]    sum;
  logic [15:0]    sr_next;

  assign s2_adv = !sr_valid || sr_ready;
  assign accept = !v1 || s2_adv;
  // Held in reset, no requester is acknowledged.
  assign take   = reset && accept && gnt_any;

  // Search upward from ptr+1 (mod NREQ) for the first pending request.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDW'((32'(ptr) + k) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // One-hot ack and operand mux for the granted requester.
  always_comb begin
    ack    = '0;
    sel_dq = '0;
    sel_se = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        ack[i] = take;
        sel_dq = dq[16*i +: 16];
        sel_se = se[15*i +: 15];
      end
    end
  end

  // Sign-magnitude DQ to two's complement, sign-extended SE, and the add.
  always_comb begin
    dqi     = op_dq[15] ? (16'd0 - {1'b0, op_dq[14:0]}) : op_dq;
    sei     = {op_se[14], op_se};
    sum     = dqi + sei;
    sr_next = sum;
`ifdef ADDB_SR_SAT_EN
    if ((dqi[15] == sei[15]) && (sum[15] != dqi[15])) begin
      sr_next = dqi[15] ? 16'h8000 : 16'h7FFF;
    end
`endif
  end

  // Round-robin pointer follows the last granted index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= IDW'(NREQ - 1);
    end else if (take) begin
      ptr <= gnt_idx;
    end
  end

  // Stage 1: operand register, holds when the pipeline cannot accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1    <= 1'b0;
      op_dq <= '0;
      op_se <= '0;
      op_id <= '0;
    end else if (accept) begin
      v1 <= gnt_any;
      if (gnt_any) begin
        op_dq <= sel_dq;
        op_se <= sel_se;
        op_id <= gnt_idx;
      end
    end
  end

  // Stage 2: output register, frozen while a result waits for sr_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_valid <= 1'b0;
      sr       <= '0;
      sr_id    <= '0;
    end else if (s2_adv) begin
      sr_valid <= v1;
      if (v1) begin
        sr    <= sr_next;
        sr_id <= op_id;
      end
    end
  end

  // Delivered-result counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_count <= '0;
    end else if (sr_valid && sr_ready) begin
      sr_count <= sr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_addb_rr_sched.sv
// Directed self-checking bench for addb_rr_sched (NREQ=4, IDW=2).
module tb_addb_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  dq;
  logic [15*NREQ-1:0]  se;
  logic [NREQ-1:0]     ack;
  logic                sr_valid;
  logic                sr_ready;
  logic [15:0]         sr;
  logic [IDW-1:0]      sr_id;
  logic [15:0]         sr_count;

  int checks = 0;
  int errors = 0;

  addb_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .dq       (dq),
    .se       (se),
    .ack      (ack),
    .sr_valid (sr_valid),
    .sr_ready (sr_ready),
    .sr       (sr),
    .sr_id    (sr_id),
    .sr_count (sr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int id, input logic [15:0] dqv, input logic [14:0] sev);
    dq[16*id +: 16] = dqv;
    se[15*id +: 15] = sev;
  endtask

  // Single isolated transaction on requester id; result expected two cycles later.
  task automatic do_one(input string tag, input int id, input logic [15:0] dqv,
                        input logic [14:0] sev, input logic [15:0] exp_sr);
    req = '0;
    req[id] = 1'b1;
    set_op(id, dqv, sev);
    #1;
    check({tag, "_ack"}, 32'(ack), 32'(1 << id));
    tick;
    req = '0;
    #1;
    check({tag, "_v_early"}, 32'(sr_valid), 32'd0);
    tick;
    check({tag, "_valid"}, 32'(sr_valid), 32'd1);
    check({tag, "_sr"}, 32'(sr), 32'(exp_sr));
    check({tag, "_id"}, 32'(sr_id), 32'(id));
    tick;
  endtask

  logic [15:0] ovf_pos_exp;
  logic [15:0] ovf_neg_exp;
  logic [15:0] rr_sr [NREQ];

  initial begin
`ifdef ADDB_SR_SAT_EN
    ovf_pos_exp = 16'h7FFF;
    ovf_neg_exp = 16'h8000;
`else
    ovf_pos_exp = 16'hBFFE;
    ovf_neg_exp = 16'h4001;
`endif
    for (int i = 0; i < NREQ; i++) rr_sr[i] = 16'(16 * i + 1 + i);

    reset    = 1'b0;
    req      = '0;
    dq       = '0;
    se       = '0;
    sr_ready = 1'b1;
    tick;
    tick;
    check("rst_ack",   32'(ack),      32'd0);
    check("rst_valid", 32'(sr_valid), 32'd0);
    check("rst_sr",    32'(sr),       32'd0);
    check("rst_id",    32'(sr_id),    32'd0);
    check("rst_count", 32'(sr_count), 32'd0);
    reset = 1'b1;

    // Basic add with counter tracking
    check("basic_cnt0", 32'(sr_count), 32'd0);
    do_one("basic", 0, 16'h0005, 15'h0003, 16'h0008);
    check("basic_cnt1", 32'(sr_count), 32'd1);
    check("basic_idle", 32'(sr_valid), 32'd0);

    do_one("neg",     1, 16'h8005, 15'h7FFD, 16'hFFF8);
    do_one("negzero", 2, 16'h8000, 15'h0000, 16'h0000);
    do_one("ovf_pos", 3, 16'h7FFF, 15'h3FFF, ovf_pos_exp);
    do_one("ovf_neg", 0, 16'hFFFF, 15'h4000, ovf_neg_exp);
    check("cnt5", 32'(sr_count), 32'd5);

    // Round robin: all requests held from reset, consumer always ready
    reset = 1'b0;
    req   = '1;
    for (int i = 0; i < NREQ; i++) set_op(i, 16'(16 * i + 1), 15'(i));
    #1;
    check("rr_rst_ack", 32'(ack), 32'd0);
    check("rr_rst_cnt", 32'(sr_count), 32'd0);
    tick;
    reset = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check("rr_ack", 32'(ack), 32'(1 << (k % NREQ)));
      if (k >= 2) begin
        check("rr_valid", 32'(sr_valid), 32'd1);
        check("rr_id",    32'(sr_id),    32'((k - 2) % NREQ));
        check("rr_sr",    32'(sr),       32'(rr_sr[(k - 2) % NREQ]));
        check("rr_cnt",   32'(sr_count), 32'(k - 2));
      end else begin
        check("rr_vlat", 32'(sr_valid), 32'd0);
      end
      tick;
    end

    // Backpressure from idle: 5 stalled cycles, only two acks fit
    reset = 1'b0;
    req   = '0;
    tick;
    reset    = 1'b1;
    sr_ready = 1'b0;
    req      = 4'b1111;
    #1;
    check("bp_ack0", 32'(ack), 32'b0001);
    tick;
    req = 4'b1110;
    #1;
    check("bp_ack1", 32'(ack), 32'b0010);
    tick;
    req = 4'b1100;
    for (int k = 2; k < 5; k++) begin
      #1;
      check("bp_stall_ack", 32'(ack),      32'd0);
      check("bp_stall_v",   32'(sr_valid), 32'd1);
      check("bp_stall_id",  32'(sr_id),    32'd0);
      check("bp_stall_sr",  32'(sr),       32'(rr_sr[0]));
      check("bp_stall_cnt", 32'(sr_count), 32'd0);
      tick;
    end
    sr_ready = 1'b1;
    #1;
    check("bp_ack2", 32'(ack),   32'b0100);
    check("bp_id0",  32'(sr_id), 32'd0);
    tick;
    req = 4'b1000;
    #1;
    check("bp_ack3", 32'(ack),   32'b1000);
    check("bp_id1",  32'(sr_id), 32'd1);
    check("bp_sr1",  32'(sr),    32'(rr_sr[1]));
    tick;
    req = '0;
    #1;
    check("bp_ack_none", 32'(ack),   32'd0);
    check("bp_id2",      32'(sr_id), 32'd2);
    check("bp_sr2",      32'(sr),    32'(rr_sr[2]));
    tick;
    check("bp_v3",  32'(sr_valid), 32'd1);
    check("bp_id3", 32'(sr_id),    32'd3);
    check("bp_sr3", 32'(sr),       32'(rr_sr[3]));
    tick;
    check("bp_drain", 32'(sr_valid), 32'd0);
    check("bp_cnt4",  32'(sr_count), 32'd4);

    // Reset while a result is in flight
    req = 4'b1010;
    #1;
    check("mr_ack1", 32'(ack), 32'b0010);
    tick;
    req = 4'b1000;
    #1;
    check("mr_ack3", 32'(ack), 32'b1000);
    tick;
    req = '0;
    check("mr_valid", 32'(sr_valid), 32'd1);
    check("mr_id",    32'(sr_id),    32'd1);
    #1;
    reset = 1'b0;
    req   = 4'b1100;
    #1;
    check("mr_v0",   32'(sr_valid), 32'd0);
    check("mr_sr0",  32'(sr),       32'd0);
    check("mr_id0",  32'(sr_id),    32'd0);
    check("mr_cnt0", 32'(sr_count), 32'd0);
    check("mr_ack0", 32'(ack),      32'd0);
    tick;
    reset = 1'b1;
    #1;
    check("mr_first", 32'(ack), 32'b0100);
    tick;
    req = '0;
    tick;
    check("mr_res_id", 32'(sr_id), 32'd2);
    check("mr_res_sr", 32'(sr),    32'(rr_sr[2]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addb_rr_sched.md
Name: addb_rr_sched

Overview:
- Round-robin scheduler that shares one reconstruction adder (SR = DQ + SE) among NREQ channel requesters in the single-resource MCAC datapath.
- Each requester presents a sign-magnitude DQ and a two's-complement SE with a req/ack handshake.
- The block arbitrates, runs the adder in a 2-stage stallable pipeline, and returns SR tagged with the requester id under valid/ready.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, width of requester id; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request level.
- dq  input  16*NREQ  DQ for requester i at [16i+15:16i]; sign-magnitude, bit15 = sign.
- se  input  15*NREQ  SE for requester i at [15i+14:15i]; 15-bit two's complement.
- ack  output  NREQ  one-hot accept pulse; operands are sampled at the clock edge ending the ack cycle.
- sr_valid  output  1  result valid.
- sr_ready  input  1  consumer accepts the result when high with sr_valid.
- sr  output  16  reconstructed signal, 16-bit two's complement.
- sr_id  output  IDW  requester index that produced sr.
- sr_count  output  16  count of delivered results (sr_valid & sr_ready); wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - ack=0, sr_valid=0, sr=0, sr_id=0, sr_count=0.
  - Stage-1 valid cleared.
  - RR pointer = NREQ-1, so requester 0 wins first.
- Requester protocol:
  - Hold req high and operands stable until the ack cycle; drop or renew req on the following cycle.
  - The block never acks a requester whose req is low.
- Arbitration (combinational):
  - accept = !v1 | s2_adv, where s2_adv = !sr_valid | sr_ready.
  - When accept is high and any req is high, grant the first req at or after ptr+1 (mod NREQ), searching upward.
  - ack = one-hot grant & accept.
  - On ack, ptr <= granted index. With no ack, ptr holds.
- Stage 1 (operand register):
  - On ack: capture dq, se and id of the granted requester; v1 <= 1.
  - On accept without a grant: v1 <= 0.
  - When !accept: hold all stage-1 state.
- Stage 2 (output register, loaded when s2_adv):
  - sr_valid <= v1.
  - If v1: sr <= f(op), sr_id <= id.
  - While sr_valid & !sr_ready: sr, sr_id and sr_valid hold stable.
- Arithmetic f:
  - DQI = DQ[15] ? (2^16 - {1'b0,DQ[14:0]}) mod 2^16 : DQ.
  - SEI = sign-extend SE to 16 bits.
  - SR = (DQI + SEI) mod 2^16 (wraps unless SR_SAT_EN).
  - Negative zero DQ (0x8000) gives DQI = 0x0000.
- Latency and throughput:
  - ack in cycle n -> sr_valid in cycle n+2 with no stall.
  - Throughput is one result per cycle.
  - Under sustained requests, ids rotate 0,1,...,NREQ-1.
- Full pipeline: with v1 and sr_valid both high and sr_ready low, ack=0 and nothing is lost or duplicated.
- Simultaneous events: sr_ready high with a new grant in the same cycle -> stage 2 takes the stage-1 result and stage 1 takes the new operands.
- Reset mid-operation: in-flight results are discarded, no ack is issued, and the pointer reinitialises.
- sr_count increments on each sr_valid & sr_ready cycle; 0xFFFF wraps to 0x0000.

Optional Feature:
- Macro ADDB_SR_SAT_EN.
- Defined: on signed overflow of DQI+SEI (operand signs equal, result sign differs), clamp SR to 0x7FFF for positive or 0x8000 for negative overflow.
- Undefined: SR wraps mod 2^16, bit-exact with the existing adder.

Test Plan:
- Basic add: req[0], DQ=0x0005, SE=0x0003 -> ack[0] pulse; 2 cycles later sr=0x0008, sr_id=0, sr_count 0->1.
- Negative operands: DQ=0x8005, SE=0x7FFD -> sr=0xFFF8. Negative zero: DQ=0x8000, SE=0x0000 -> sr=0x0000.
- Round robin: all four req held high from reset, sr_ready=1 -> acks 0,1,2,3,0 on consecutive cycles; sr_id sequence matches; one result per cycle.
- Backpressure: sr_ready=0 for 5 cycles with 4 requests pending -> at most 2 acks; sr/sr_id stable while stalled; after release all 4 results in order, none duplicated.
- Overflow: DQ=0x7FFF, SE=0x3FFF -> sr=0xBFFE without macro; sr=0x7FFF with ADDB_SR_SAT_EN.
- Reset mid-stream: assert reset while sr_valid=1 -> outputs 0 asynchronously; after release the first grant goes to the lowest requesting index.
